// File: rtl/if_fetch_stage.sv
// Instruction fetch: one outstanding imem request and a response FIFO feeding the IF/ID register. An empty FIFO is bypassed, so rsp -> IF/ID takes 1 cycle.
// Decode stall holds IF/ID while the FIFO keeps filling; a redirect flushes everything. Optional IF_PERF_CNT_EN adds fetch/squash counters.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        ex_take_branch,
  input  logic [31:0] ex_target_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] if_id_IR,
  output logic [31:0] if_id_PC,
  output logic [31:0] if_id_NPC,
  output logic        if_id_valid_inst
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_squashed
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_SQUASH} state_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc, fetch_pc_nxt;
  logic [31:0]   fifo_ir [FIFO_DEPTH];
  logic [31:0]   fifo_pc [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          fifo_empty, accept, rsp_take, bypass, push, pop;
  logic [31:0]   rsp_pc, head_pc;
  logic          unused_tgt_lsb;

  assign unused_tgt_lsb = ^ex_target_pc[1:0];

  // fetch_pc only moves on accept or redirect, so in WAIT it is one word past the outstanding request
  assign rsp_pc     = fetch_pc - 32'd4;
  assign head_pc    = fifo_pc[rd_ptr];
  assign fifo_empty = (count == '0);

  assign imem_req_valid = !rst && (state == S_FETCH) && (count < DEPTH_C) && !ex_take_branch;
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;

  assign rsp_take = (state == S_WAIT) && imem_rsp_valid && !ex_take_branch;
  assign bypass   = rsp_take && fifo_empty && !stall;
  assign push     = rsp_take && !bypass;
  assign pop      = !ex_take_branch && !stall && !fifo_empty;

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    case (state)
      S_FETCH:  if (accept) state_nxt = S_WAIT;
      S_WAIT: begin
        if (imem_rsp_valid)      state_nxt = S_FETCH;
        else if (ex_take_branch) state_nxt = S_SQUASH;
      end
      S_SQUASH: if (imem_rsp_valid) state_nxt = S_FETCH;
      default:  state_nxt = S_FETCH;
    endcase
    if (ex_take_branch) fetch_pc_nxt = {ex_target_pc[31:2], 2'b00};
    else if (accept)    fetch_pc_nxt = fetch_pc + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_ir[wr_ptr] <= imem_rsp_data;
      fifo_pc[wr_ptr] <= rsp_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || ex_take_branch) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Bubble leaves PC/NPC untouched; only valid and IR define a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_IR         <= NOP_INST;
      if_id_PC         <= 32'd0;
      if_id_NPC        <= 32'd4;
      if_id_valid_inst <= 1'b0;
    end else if (ex_take_branch) begin
      if_id_IR         <= NOP_INST;
      if_id_valid_inst <= 1'b0;
    end else if (!stall) begin
      if (!fifo_empty) begin
        if_id_IR         <= fifo_ir[rd_ptr];
        if_id_PC         <= head_pc;
        if_id_NPC        <= head_pc + 32'd4;
        if_id_valid_inst <= 1'b1;
      end else if (bypass) begin
        if_id_IR         <= imem_rsp_data;
        if_id_PC         <= rsp_pc;
        if_id_NPC        <= rsp_pc + 32'd4;
        if_id_valid_inst <= 1'b1;
      end else begin
        if_id_IR         <= NOP_INST;
        if_id_valid_inst <= 1'b0;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  logic rsp_drop;
  // A response landing in the redirect cycle is dropped rather than pushed and flushed
  assign rsp_drop = imem_rsp_valid && ((state == S_SQUASH) || ((state == S_WAIT) && ex_take_branch));

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched  <= 32'd0;
      perf_squashed <= 32'd0;
    end else begin
      perf_fetched  <= perf_fetched + 32'(rsp_take);
      perf_squashed <= perf_squashed + 32'(rsp_drop) + (ex_take_branch ? 32'(count) : 32'd0);
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios then random traffic, checked every cycle against an in-order queue model.
module tb_if_fetch_stage;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          FIFO_DEPTH = 2;
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stall, ex_take_branch;
  logic [31:0] ex_target_pc;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic [31:0] if_id_IR, if_id_PC, if_id_NPC;
  logic        if_id_valid_inst;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_squashed;
`endif

  if_fetch_stage #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH), .NOP_INST(NOP_INST)) dut (
    .clk(clk), .rst(rst), .stall(stall), .ex_take_branch(ex_take_branch), .ex_target_pc(ex_target_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_id_IR(if_id_IR), .if_id_PC(if_id_PC), .if_id_NPC(if_id_NPC), .if_id_valid_inst(if_id_valid_inst)
`ifdef IF_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_squashed(perf_squashed)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] ir; logic [31:0] pc; } ent_t;

  int n_asrt = 0, n_fail = 0;
  // memory environment
  logic        ready_en = 1'b1, mem_pend = 1'b0;
  logic [31:0] mem_addr = '0;
  int          mem_cnt = 0, lat_mode = 1;
  logic        last_acc;
  logic [31:0] last_acc_addr;
  // reference model: fetch stream as a queue of delivered-but-not-decoded words
  ent_t        m_q[$];
  logic        m_out = 1'b0, m_sq = 1'b0;
  logic [31:0] m_pc, m_opc;
  logic [31:0] m_fet = 0, m_sqd = 0;
  logic        e_valid;
  logic [31:0] e_ir, e_pc, e_npc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    logic exp_req, acc, got, was_rst;
    logic [31:0] data;
    ent_t ent;
    imem_req_ready = ready_en && !mem_pend;
    if (mem_pend && mem_cnt == 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    @(negedge clk);
    exp_req = !rst && !ex_take_branch && !m_out && (m_q.size() < FIFO_DEPTH);
    chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
    if (exp_req) chk("req_addr", imem_req_addr, m_pc);
    acc           = exp_req && imem_req_ready;
    last_acc      = imem_req_valid && imem_req_ready;
    last_acc_addr = imem_req_addr;
    got           = imem_rsp_valid;
    data          = imem_rsp_data;
    was_rst       = rst;
    if (imem_rsp_valid) mem_pend = 1'b0;
    else if (mem_pend)  mem_cnt--;
    if (last_acc) begin
      mem_pend = 1'b1;
      mem_addr = imem_req_addr;
      mem_cnt  = (lat_mode == 0) ? $urandom_range(0, 3) : lat_mode - 1;
    end
    if (rst) begin
      m_q.delete();
      m_out = 1'b0; m_sq = 1'b0; m_pc = RESET_PC; m_fet = 0; m_sqd = 0;
      e_valid = 1'b0; e_ir = NOP_INST; e_pc = 32'd0; e_npc = 32'd4;
    end else begin
      if (got && m_out) begin
        m_out = 1'b0;
        if (m_sq || ex_take_branch) m_sqd++;
        else begin
          m_q.push_back('{data, m_opc});
          m_fet++;
          chk("fifo_overflow", 32'(m_q.size() <= FIFO_DEPTH), 32'd1);
        end
      end
      if (ex_take_branch) begin
        m_sqd += 32'(m_q.size());
        m_q.delete();
        m_pc = {ex_target_pc[31:2], 2'b00};
        m_sq = m_out;
        e_valid = 1'b0; e_ir = NOP_INST;
      end else if (!stall) begin
        if (m_q.size() > 0) begin
          ent = m_q.pop_front();
          e_valid = 1'b1; e_ir = ent.ir; e_pc = ent.pc; e_npc = ent.pc + 32'd4;
        end else begin
          e_valid = 1'b0; e_ir = NOP_INST;
        end
      end
      if (acc) begin
        m_out = 1'b1; m_sq = 1'b0; m_opc = m_pc; m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    chk("if_valid", 32'(if_id_valid_inst), 32'(e_valid));
    chk("if_ir", if_id_IR, e_ir);
    if (e_valid || was_rst) begin
      chk("if_pc", if_id_PC, e_pc);
      chk("if_npc", if_id_NPC, e_npc);
    end
`ifdef IF_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, m_fet);
    chk("perf_squashed", perf_squashed, m_sqd);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; ex_take_branch = 1'b0; ex_target_pc = '0;
    cycle(); cycle();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int limit);
    bit found = 0;
    for (int i = 0; i < limit && !found; i++) begin
      cycle();
      found = if_id_valid_inst;
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  task automatic wait_acc(input string tag, input int limit);
    bit found = 0;
    for (int i = 0; i < limit && !found; i++) begin
      cycle();
      found = last_acc;
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  initial begin
    logic [31:0] sq0;
    do_reset();
    // 1: three words back to back, 1-cycle latency
    lat_mode = 1;
    for (int k = 0; k < 3; k++) begin
      wait_valid("t1_timeout", 8);
      chk("t1_pc", if_id_PC, 32'(k * 4));
      chk("t1_ir", if_id_IR, mem_word(32'(k * 4)));
      chk("t1_valid", 32'(if_id_valid_inst), 32'd1);
    end

    // 2: stall while the FIFO fills, then drain 8, 12 with no gap
    do_reset();
    wait_valid("t2_timeout0", 8);
    wait_valid("t2_timeout4", 8);
    chk("t2_pc4", if_id_PC, 32'd4);
    stall = 1'b1;
    for (int k = 0; k < 5; k++) cycle();
    chk("t2_hold_pc", if_id_PC, 32'd4);
    chk("t2_full_noreq", 32'(imem_req_valid), 32'd0);
    stall = 1'b0;
    cycle(); chk("t2_pc8", if_id_PC, 32'd8);  chk("t2_v8", 32'(if_id_valid_inst), 32'd1);
    cycle(); chk("t2_pc12", if_id_PC, 32'd12); chk("t2_v12", 32'(if_id_valid_inst), 32'd1);

    // 3: redirect while a response is outstanding
    do_reset();
    lat_mode = 3;
    wait_acc("t3_acc_timeout", 4);
    sq0 = m_sqd;
    ex_take_branch = 1'b1; ex_target_pc = 32'h0000_0103;
    cycle();
    ex_take_branch = 1'b0;
    chk("t3_bubble", 32'(if_id_valid_inst), 32'd0);
    wait_valid("t3_timeout", 16);
    chk("t3_pc", if_id_PC, 32'h0000_0100);
    chk("t3_npc", if_id_NPC, 32'h0000_0104);
`ifdef IF_PERF_CNT_EN
    chk("t3_squashed", perf_squashed - sq0, 32'd1);
`endif

    // 4: redirect beats stall
    stall = 1'b1; ex_take_branch = 1'b1; ex_target_pc = 32'h0000_0200;
    cycle();
    chk("t4_valid", 32'(if_id_valid_inst), 32'd0);
    chk("t4_ir", if_id_IR, 32'h0000_0013);
    stall = 1'b0; ex_take_branch = 1'b0;

    // 5: memory not ready for 5 cycles
    do_reset();
    lat_mode = 1; ready_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("t5_req_hold", 32'(imem_req_valid), 32'd1);
      chk("t5_addr_hold", imem_req_addr, RESET_PC);
    end
    ready_en = 1'b1;
    wait_acc("t5_acc_timeout", 4);
    chk("t5_resume_addr", last_acc_addr, RESET_PC);

    // 6: address wrap, then reset while waiting
    ex_take_branch = 1'b1; ex_target_pc = 32'hFFFF_FFFC;
    cycle();
    ex_take_branch = 1'b0;
    wait_acc("t6_acc_top", 8);
    chk("t6_top_addr", last_acc_addr, 32'hFFFF_FFFC);
    wait_acc("t6_acc_wrap", 8);
    chk("t6_wrap_addr", last_acc_addr, 32'h0000_0000);
    lat_mode = 3;
    for (int k = 0; k < 40 && !(last_acc && last_acc_addr == 32'd8); k++) cycle();
    chk("t6_acc8", last_acc_addr, 32'd8);
    cycle();
    rst = 1'b1; cycle(); rst = 1'b0;
    wait_valid("t6_timeout", 20);
    chk("t6_pc", if_id_PC, RESET_PC);
    chk("t6_ir", if_id_IR, mem_word(RESET_PC));

    // random traffic
    lat_mode = 0;
    for (int k = 0; k < 3000; k++) begin
      ready_en       = ($urandom_range(0, 3) != 0);
      stall          = ($urandom_range(0, 3) == 0);
      ex_take_branch = ($urandom_range(0, 24) == 0);
      ex_target_pc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
